// File: rtl/dsm_ctrl_pkg.sv
// Shared definitions for the DSM control blocks: NCO step format and sweep FSM states.
package dsm_ctrl_pkg;

    localparam int unsigned ACC_INT_WIDTH  = 8;
    localparam int unsigned ACC_FRAC_WIDTH = 24;
    localparam int unsigned ACC_WIDTH      = ACC_INT_WIDTH + ACC_FRAC_WIDTH;
    localparam int unsigned DWELL_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Config handshake, sweep control and NCO step outputs of the sweep controller.
interface nco_sweep_ctrl_if #(
    parameter int unsigned ACC_WIDTH   = dsm_ctrl_pkg::ACC_WIDTH,
    parameter int unsigned DWELL_WIDTH = dsm_ctrl_pkg::DWELL_WIDTH
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [ACC_WIDTH-1:0]   cfg_start;
    logic [ACC_WIDTH-1:0]   cfg_stop;
    logic [ACC_WIDTH-1:0]   cfg_incr;
    logic [DWELL_WIDTH-1:0] cfg_dwell;
    logic                   cfg_loop;
    logic                   start;
    logic                   abort;
    logic [ACC_WIDTH-1:0]   nco_step;
    logic                   nco_step_enable;
    logic                   busy;
    logic                   done;

    modport master (
        output cfg_valid, cfg_start, cfg_stop, cfg_incr, cfg_dwell, cfg_loop, start, abort,
        input  cfg_ready, nco_step, nco_step_enable, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_start, cfg_stop, cfg_incr, cfg_dwell, cfg_loop, start, abort,
        output cfg_ready, nco_step, nco_step_enable, busy, done
    );

endinterface

// File: rtl/dwell_timer.sv
// Per-point dwell countdown: load a value, count down to zero while enabled, flag zero.
module dwell_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep controller: steps the NCO phase increment from start to stop,
// holding each point for dwell+1 cycles, optionally looping.
module nco_sweep_ctrl #(
    parameter int unsigned ACC_WIDTH   = dsm_ctrl_pkg::ACC_WIDTH,
    parameter int unsigned DWELL_WIDTH = dsm_ctrl_pkg::DWELL_WIDTH
) (
    input  logic             aclk,
    input  logic             rst,
    nco_sweep_ctrl_if.slave  bus
);
    import dsm_ctrl_pkg::*;

    sweep_state_t           state_q, state_d;
    logic [ACC_WIDTH-1:0]   start_q, stop_q, incr_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic                   loop_q;
    logic [ACC_WIDTH-1:0]   step_q, step_d;
    logic                   stb_q, stb_d;
    logic                   tmr_load, tmr_zero;
    logic                   cfg_fire;
    logic [ACC_WIDTH:0]     next_sum;
    logic                   next_fits;

    assign cfg_fire  = bus.cfg_valid && bus.cfg_ready;

    // Extra bit catches wrap past full scale, which must end the sweep.
    assign next_sum  = {1'b0, step_q} + {1'b0, incr_q};
    assign next_fits = !next_sum[ACC_WIDTH] && (next_sum[ACC_WIDTH-1:0] <= stop_q);

    dwell_timer #(
        .WIDTH (DWELL_WIDTH)
    ) u_dwell (
        .aclk       (aclk),
        .rst        (rst),
        .load_i     (tmr_load),
        .en_i       (state_q == RUN),
        .load_val_i (dwell_q),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        stb_d    = 1'b0;
        tmr_load = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start && !bus.abort) begin
                    state_d  = RUN;
                    step_d   = start_q;
                    stb_d    = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    if (next_fits) begin
                        step_d   = next_sum[ACC_WIDTH-1:0];
                        stb_d    = 1'b1;
                        tmr_load = 1'b1;
                    end else if (loop_q) begin
                        step_d   = start_q;
                        stb_d    = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            stb_q   <= 1'b0;
            start_q <= '0;
            stop_q  <= '0;
            incr_q  <= '0;
            dwell_q <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            stb_q   <= stb_d;
            if (cfg_fire) begin
                start_q <= bus.cfg_start;
                stop_q  <= bus.cfg_stop;
                incr_q  <= bus.cfg_incr;
                dwell_q <= bus.cfg_dwell;
                loop_q  <= bus.cfg_loop;
            end
        end
    end

    assign bus.cfg_ready       = (state_q != RUN);
    assign bus.nco_step        = step_q;
    assign bus.nco_step_enable = stb_q;
    assign bus.busy            = (state_q == RUN);
    assign bus.done            = (state_q == DONE);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: expected strobes/done pulses are queued with
// their cycle numbers before each launch and matched as the DUT produces them.
module tb_nco_sweep_ctrl;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    logic aclk = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;

    ev_t  stb_q[$];
    int   done_q[$];
    ev_t  mon_e;
    int   mon_d;
    int   e;
    int   e2;

    nco_sweep_ctrl_if #(.ACC_WIDTH(32), .DWELL_WIDTH(16)) bus ();

    nco_sweep_ctrl #(
        .ACC_WIDTH   (32),
        .DWELL_WIDTH (16)
    ) dut (
        .aclk (aclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic push_stb(input int c, input logic [31:0] v);
        ev_t t;
        t.cyc = c;
        t.val = v;
        stb_q.push_back(t);
    endtask

    // Reference model of a non-looping sweep launched so that its first point lands at cycle c0.
    task automatic push_sweep(input int c0, input logic [31:0] s, input logic [31:0] stop,
                              input logic [31:0] inc, input int dwell);
        longint unsigned p;
        longint unsigned nx;
        int c;
        p = {32'h0, s};
        c = c0;
        for (int i = 0; i < 64; i++) begin
            push_stb(c, p[31:0]);
            nx = p + {32'h0, inc};
            if (nx > {32'h0, stop}) begin
                done_q.push_back(c + dwell + 1);
                break;
            end
            p = nx;
            c = c + dwell + 1;
        end
    endtask

    task automatic cfg(input logic [31:0] s, input logic [31:0] stop, input logic [31:0] inc,
                       input logic [15:0] dw, input logic lp);
        bus.cfg_start = s;
        bus.cfg_stop  = stop;
        bus.cfg_incr  = inc;
        bus.cfg_dwell = dw;
        bus.cfg_loop  = lp;
        bus.cfg_valid = 1'b1;
        check("cfg_ready_idle", bus.cfg_ready, 1);
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic launch();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    always @(negedge aclk) begin
        if (bus.nco_step_enable) begin
            if (stb_q.size() == 0) begin
                check("stb_unexpected", bus.nco_step_enable, 1'b0);
            end else begin
                mon_e = stb_q.pop_front();
                check("stb_cycle", cyc, mon_e.cyc);
                check("stb_value", bus.nco_step, mon_e.val);
            end
        end
        if (bus.done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", bus.done, 1'b0);
            end else begin
                mon_d = done_q.pop_front();
                check("done_cycle", cyc, mon_d);
            end
        end
    end

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_start = '0;
        bus.cfg_stop  = '0;
        bus.cfg_incr  = '0;
        bus.cfg_dwell = '0;
        bus.cfg_loop  = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        repeat (3) tick();
        check("rst_step", bus.nco_step, 0);
        check("rst_stb", bus.nco_step_enable, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ready", bus.cfg_ready, 1);
        rst = 1'b0;
        tick();

        // Reset must clear the shadow config: a sweep of all-zero config holds 0 every cycle.
        cfg(32'd100, 32'd130, 32'd10, 16'd3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e = cyc + 1;
        push_stb(e, 32'd0);
        push_stb(e + 1, 32'd0);
        push_stb(e + 2, 32'd0);
        launch();
        repeat (2) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("shadow_abort_busy", bus.busy, 0);
        check("shadow_abort_step", bus.nco_step, 0);

        // Basic sweep, config write blocked mid-run, restart from DONE keeps the old stop.
        cfg(32'd100, 32'd130, 32'd10, 16'd3, 1'b0);
        e = cyc + 1;
        push_sweep(e, 32'd100, 32'd130, 32'd10, 3);
        launch();
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) tick();
            check("busy_sweep", bus.busy, 64'(k <= 15));
            if (k == 2) begin
                bus.cfg_stop  = 32'd50;
                bus.cfg_valid = 1'b1;
                check("cfg_ready_run", bus.cfg_ready, 0);
            end
            if (k == 3) bus.cfg_valid = 1'b0;
            if (k == 16) begin
                check("hold_in_done", bus.nco_step, 32'd130);
                e2 = cyc + 1;
                push_sweep(e2, 32'd100, 32'd130, 32'd10, 3);
                bus.start = 1'b1;
            end
        end
        tick();
        bus.start = 1'b0;
        repeat (17) tick();
        check("restart_idle_busy", bus.busy, 0);
        check("restart_hold_step", bus.nco_step, 32'd130);

        // Looping sweep: start point returns with a strobe, abort ends without done.
        cfg(32'd100, 32'd130, 32'd10, 16'd3, 1'b1);
        e = cyc + 1;
        push_stb(e, 32'd100);
        push_stb(e + 4, 32'd110);
        push_stb(e + 8, 32'd120);
        push_stb(e + 12, 32'd130);
        push_stb(e + 16, 32'd100);
        launch();
        repeat (19) tick();
        check("loop_busy", bus.busy, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("loop_abort_busy", bus.busy, 0);
        check("loop_abort_step", bus.nco_step, 32'd100);
        check("loop_abort_ready", bus.cfg_ready, 1);

        // Carry out of the step accumulator ends the sweep after one point.
        cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 1'b0);
        e = cyc + 1;
        push_sweep(e, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0);
        launch();
        repeat (3) tick();
        check("wrap_hold_step", bus.nco_step, 32'hFFFF_FFF0);

        // start > stop gives a single point then done.
        cfg(32'd200, 32'd100, 32'd5, 16'd2, 1'b0);
        e = cyc + 1;
        push_sweep(e, 32'd200, 32'd100, 32'd5, 2);
        launch();
        repeat (5) tick();
        check("rev_busy", bus.busy, 0);

        // start together with abort in IDLE stays IDLE.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("sa_busy", bus.busy, 0);
        check("sa_step", bus.nco_step, 32'd200);
        tick();
        check("sa_busy_hold", bus.busy, 0);

        // Zero increment holds the start point until aborted.
        cfg(32'd500, 32'd600, 32'd0, 16'd1, 1'b0);
        e = cyc + 1;
        for (int i = 0; i < 15; i++) push_stb(e + 2 * i, 32'd500);
        launch();
        repeat (29) tick();
        check("zinc_busy", bus.busy, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("zinc_abort_busy", bus.busy, 0);
        check("zinc_abort_step", bus.nco_step, 32'd500);

        // Reset in the middle of a sweep.
        cfg(32'd100, 32'd130, 32'd10, 16'd3, 1'b0);
        e = cyc + 1;
        push_stb(e, 32'd100);
        push_stb(e + 4, 32'd110);
        launch();
        repeat (5) tick();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.cfg_valid = 1'b1;
        tick();
        check("mid_rst_step", bus.nco_step, 0);
        check("mid_rst_stb", bus.nco_step_enable, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_ready", bus.cfg_ready, 1);
        rst = 1'b0;
        bus.start = 1'b0;
        bus.cfg_valid = 1'b0;
        repeat (3) tick();

        check("stb_queue_empty", stb_q.size(), 0);
        check("done_queue_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
